// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-search pipeline.
// Holds the KSA state encoding, S-array depth and the byte type.
package rc4_pkg;

  localparam int S_DEPTH           = 256;
  localparam int KEY_BYTES_DEFAULT = 3;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    KSA_RD_I,
    KSA_RD_J,
    KSA_WR_I,
    KSA_WR_J,
    DONE
  } ksa_state_t;

endpackage

// File: rtl/ksa_engine_if.sv
// Handshake and S-RAM bus between the key generator, ksa_engine and the S-RAM.
// master = engine side, slave = key generator / RAM side.
interface ksa_engine_if #(
  parameter int KEY_BYTES = rc4_pkg::KEY_BYTES_DEFAULT
);
  import rc4_pkg::*;

  logic                   start;
  logic [8*KEY_BYTES-1:0] secret_key;
  logic                   ready;
  logic                   done;
  byte_t                  s_addr;
  byte_t                  s_wrdata;
  logic                   s_wren;
  byte_t                  s_rddata;

  modport master (
    input  start, secret_key, s_rddata,
    output ready, done, s_addr, s_wrdata, s_wren
  );

  modport slave (
    output start, secret_key, s_rddata,
    input  ready, done, s_addr, s_wrdata, s_wren
  );

endinterface

// File: rtl/key_byte_sel.sv
// Combinational selector of key byte k; byte 0 is the most significant byte.
// Out-of-range k yields zero.
module key_byte_sel
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = KEY_BYTES_DEFAULT,
  parameter int K_W       = 2
) (
  input  logic [8*KEY_BYTES-1:0] key,
  input  logic [K_W-1:0]         k,
  output byte_t                  key_byte
);

  byte_t key_bytes [KEY_BYTES];

  generate
    for (genvar gi = 0; gi < KEY_BYTES; gi++) begin : g_byte
      assign key_bytes[gi] = key[8*(KEY_BYTES-gi)-1 -: 8];
    end
  endgenerate

  always_comb begin
    key_byte = '0;
    for (int n = 0; n < KEY_BYTES; n++) begin
      if (k == K_W'(n)) key_byte = key_bytes[n];
    end
  end

endmodule

// File: rtl/ksa_engine.sv
// RC4 key-scheduling engine: fills S[n]=n, then runs the 256-step swap loop
// against a single-port S-RAM, one access per cycle, and pulses done.
module ksa_engine
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = KEY_BYTES_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  ksa_engine_if.master bus
);

  localparam int             K_W    = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(KEY_BYTES - 1);
  localparam byte_t          I_LAST = byte_t'(S_DEPTH - 1);

  ksa_state_t             state_reg, state_next;
  byte_t                  i_reg, i_next;
  byte_t                  j_reg, j_next;
  byte_t                  si_reg, si_next;
  logic [K_W-1:0]         k_reg, k_next;
  logic [8*KEY_BYTES-1:0] key_q_reg, key_q_next;

  byte_t key_byte;
  byte_t j_new;

  logic  ready_c, done_c, s_wren_c;
  byte_t s_addr_c, s_wrdata_c;

  key_byte_sel #(
    .KEY_BYTES (KEY_BYTES),
    .K_W       (K_W)
  ) u_key_byte_sel (
    .key      (key_q_reg),
    .k        (k_reg),
    .key_byte (key_byte)
  );

  // S[i] is on s_rddata during KSA_RD_J, so j_new is only meaningful there.
  assign j_new = j_reg + bus.s_rddata + key_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      i_reg     <= '0;
      j_reg     <= '0;
      si_reg    <= '0;
      k_reg     <= '0;
      key_q_reg <= '0;
    end else begin
      state_reg <= state_next;
      i_reg     <= i_next;
      j_reg     <= j_next;
      si_reg    <= si_next;
      k_reg     <= k_next;
      key_q_reg <= key_q_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    i_next     = i_reg;
    j_next     = j_reg;
    si_next    = si_reg;
    k_next     = k_reg;
    key_q_next = key_q_reg;
    ready_c    = 1'b0;
    done_c     = 1'b0;
    s_wren_c   = 1'b0;
    s_addr_c   = '0;
    s_wrdata_c = '0;

    case (state_reg)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.start) begin
          key_q_next = bus.secret_key;
          i_next     = '0;
          j_next     = '0;
          k_next     = '0;
          state_next = INIT;
        end
      end

      INIT: begin
        s_addr_c   = i_reg;
        s_wrdata_c = i_reg;
        s_wren_c   = 1'b1;
        i_next     = i_reg + 8'd1;
        if (i_reg == I_LAST) begin
          i_next     = '0;
          state_next = KSA_RD_I;
        end
      end

      KSA_RD_I: begin
        s_addr_c   = i_reg;
        state_next = KSA_RD_J;
      end

      KSA_RD_J: begin
        si_next    = bus.s_rddata;
        j_next     = j_new;
        s_addr_c   = j_new;
        state_next = KSA_WR_I;
      end

      // S[j] arrives now and is written straight back to S[i].
      KSA_WR_I: begin
        s_addr_c   = i_reg;
        s_wrdata_c = bus.s_rddata;
        s_wren_c   = 1'b1;
        state_next = KSA_WR_J;
      end

      KSA_WR_J: begin
        s_addr_c   = j_reg;
        s_wrdata_c = si_reg;
        s_wren_c   = 1'b1;
        i_next     = i_reg + 8'd1;
        k_next     = (k_reg == K_LAST) ? '0 : k_reg + K_W'(1);
        state_next = (i_reg == I_LAST) ? DONE : KSA_RD_I;
      end

      DONE: begin
        done_c     = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.ready    = ready_c;
  assign bus.done     = done_c;
  assign bus.s_wren   = s_wren_c;
  assign bus.s_addr   = s_addr_c;
  assign bus.s_wrdata = s_wrdata_c;

endmodule

// File: doc/ksa_engine.md
# ksa_engine

Runs the RC4 key-scheduling stage of the brute-force key search. It consumes each 24-bit candidate key from the key generator and first initialises the 256-byte S-array in external RAM to S[i]=i. It then performs the 256-iteration KSA swap loop and signals completion so the decrypt/validate stage can start. There is one engine per search core, sitting between the key generator and the PRGA/decrypt stage.

## Interface
Parameters:
- KEY_BYTES, 3: key length in bytes; key width is 8*KEY_BYTES.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request to schedule secret_key; sampled only when ready=1
- secret_key  in  8*KEY_BYTES  candidate key; byte 0 = secret_key[8*KEY_BYTES-1 -: 8] (MSB first)
- ready  out  1  high when in IDLE (decoded from state)
- done  out  1  single-cycle pulse when KSA completes
- s_addr  out  8  S-RAM address
- s_wrdata  out  8  S-RAM write data
- s_wren  out  1  S-RAM write enable
- s_rddata  in  8  S-RAM read data; valid the cycle after s_addr is presented with s_wren=0

## Operation
- States: IDLE, INIT, KSA_RD_I, KSA_RD_J, KSA_WR_I, KSA_WR_J, DONE.
- IDLE: ready=1, s_wren=0. When start=1, latch secret_key into key_q, clear i, j and the key index k, and go to INIT.
- INIT: s_addr=i, s_wrdata=i, s_wren=1, i++. After the write with i=255, clear i and go to KSA_RD_I.
- KSA_RD_I: s_addr=i, s_wren=0.
- KSA_RD_J: capture si=s_rddata. Compute j_new = j + si + key_q byte[k] (8-bit wrap). Store j and drive s_addr=j_new.
- KSA_WR_I: capture sj=s_rddata. Drive s_addr=i, s_wrdata=sj, s_wren=1.
- KSA_WR_J: drive s_addr=j, s_wrdata=si, s_wren=1. Increment i; k wraps to 0 after KEY_BYTES-1, with no modulo divider. If i was 255, go to DONE; otherwise go to KSA_RD_I.
- DONE: done=1 for one cycle, then go to IDLE.
- Arithmetic: i and j are 8 bits with natural mod-256 wrap. k is a counter of width $clog2(KEY_BYTES).

## Timing
- Reset values: state=IDLE, i=0, j=0, k=0, done=0, s_wren=0, s_addr=0, s_wrdata=0, ready=1.
- Latency:
  - start accepted at edge T; the first INIT write occurs in cycle T+1.
  - INIT takes 256 cycles and KSA takes 4×256=1024 cycles.
  - done is high in cycle T+1281, and ready is high again from T+1282.
- start is ignored outside IDLE. If start is held high through DONE, it is accepted in the first IDLE cycle.
- secret_key may change after acceptance, because key_q holds the accepted key.
- i==j: both writes go to the same address with the same value. This is legal and needs no special casing.
- Reset mid-operation: return to IDLE on the next edge with s_wren=0 from that cycle onward. S-RAM contents are then undefined, and no done pulse is produced.
- Exactly one S-RAM access per cycle, so the engine is compatible with single-port RAM.

## Structure
- Shared package rc4_pkg holds:
  - the state enum ksa_state_t,
  - S_DEPTH=256,
  - the default KEY_BYTES,
  - the byte type typedef logic [7:0] byte_t.
- Sub-module key_byte_sel, a combinational selector of key_q byte[k]. The FSM and datapath stay in ksa_engine.

## Test plan
- Reset, then start with key 24'h000249 → 256 INIT writes with S[n]=n, done exactly 1281 cycles after acceptance, ready back high the following cycle.
- Key 24'h000249, iteration 1 (i=1, si=1, byte 0x02, j 0→3) → writes S[1]=3 then S[3]=1.
- Key 24'h000000, iteration 2 (j: 0→1→3) → writes S[2]=3 then S[3]=2. Iterations 0 and 1 write identical values to the same address (i==j case).
- start pulsed repeatedly during INIT and KSA, with secret_key toggling → no restart; final RAM image matches the reference model for the originally accepted key.
- reset asserted at cycle 600 after start → s_wren=0 next cycle, ready=1, no done. A new start with 24'h3FFFFF then completes and matches the model.
- start held high continuously → back-to-back runs separated by exactly one IDLE cycle (DONE → IDLE → INIT).
